// File: rtl/config_command_parser_if.sv
// Byte-stream handshake between the MCU-side UART and the config command parser.
//   rx_data/rx_flag : received byte and its one-cycle valid strobe
//   tx_ready        : UART transmitter can accept a byte
//   tx_data/tx_use  : reply byte and its one-cycle valid strobe
// master = UART side, slave = parser side.
interface config_command_parser_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_flag;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_use;

    modport master (output rx_data, rx_flag, tx_ready, input tx_data, tx_use);
    modport slave  (input rx_data, rx_flag, tx_ready, output tx_data, tx_use);
endinterface

// File: rtl/config_command_parser.sv
// Configuration-mode command parser for a UART radio module.
// Collects C0/C2 (6-byte write), C1 (read), C3 (version) and C4 (reset) frames,
// updates the configuration registers and produces the reply stream.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   mode_sleep        : 1 = configuration mode, frame collection enabled
//   bus (slave)       : rx_data/rx_flag in, tx_ready in, tx_data/tx_use out
//   cfg_addh..option  : active configuration registers
//   cfg_save          : 1 = last write was C0, 0 = C2
//   reset_req         : one-cycle module reset request (C4)
//   busy              : FSM not idle
module config_command_parser #(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           CMD_TIMEOUT  = 960,
    parameter logic [DATA_WIDTH-1:0] DEF_ADDH     = 8'h00,
    parameter logic [DATA_WIDTH-1:0] DEF_ADDL     = 8'h00,
    parameter logic [DATA_WIDTH-1:0] DEF_SPED     = 8'h1A,
    parameter logic [DATA_WIDTH-1:0] DEF_CHAN     = 8'h17,
    parameter logic [DATA_WIDTH-1:0] DEF_OPTION   = 8'h44,
    parameter logic [DATA_WIDTH-1:0] VERSION_BYTE = 8'h0D,
    parameter logic [DATA_WIDTH-1:0] FEATURE_BYTE = 8'h14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode_sleep,
    config_command_parser_if.slave     bus,
    output logic [DATA_WIDTH-1:0]      cfg_addh,
    output logic [DATA_WIDTH-1:0]      cfg_addl,
    output logic [DATA_WIDTH-1:0]      cfg_sped,
    output logic [DATA_WIDTH-1:0]      cfg_chan,
    output logic [DATA_WIDTH-1:0]      cfg_option,
    output logic                       cfg_save,
    output logic                       reset_req,
    output logic                       busy
);
    localparam int unsigned TW = (CMD_TIMEOUT < 2) ? 1 : $clog2(CMD_TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] HEAD_C0 = DATA_WIDTH'(8'hC0);
    localparam logic [DATA_WIDTH-1:0] HEAD_C1 = DATA_WIDTH'(8'hC1);
    localparam logic [DATA_WIDTH-1:0] HEAD_C2 = DATA_WIDTH'(8'hC2);
    localparam logic [DATA_WIDTH-1:0] HEAD_C3 = DATA_WIDTH'(8'hC3);
    localparam logic [DATA_WIDTH-1:0] HEAD_C4 = DATA_WIDTH'(8'hC4);
    localparam logic [DATA_WIDTH-1:0] VER_ID  = DATA_WIDTH'(8'h32);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EXEC, S_RESPOND} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] buf_q [6];
    logic [DATA_WIDTH-1:0] buf_d [6];
    logic [2:0]            cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [2:0]            idx_q, idx_d;
    logic                  gap_q, gap_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_use_q, tx_use_d;
    logic                  rst_req_q, rst_req_d;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] addh_q, addh_d, addl_q, addl_d, sped_q, sped_d;
    logic [DATA_WIDTH-1:0] chan_q, chan_d, opt_q, opt_d;
    logic                  save_q, save_d;

    logic                  head_ok;
    logic                  wide_cmd;
    logic [2:0]            frame_len;
    logic [2:0]            reply_len;
    logic [DATA_WIDTH-1:0] reply_byte;

    assign head_ok   = bus.rx_flag && mode_sleep &&
                       (bus.rx_data inside {HEAD_C0, HEAD_C1, HEAD_C2, HEAD_C3, HEAD_C4});
    assign wide_cmd  = (cmd_q == HEAD_C0) || (cmd_q == HEAD_C2);
    assign frame_len = wide_cmd ? 3'd6 : 3'd3;
    assign reply_len = (cmd_q == HEAD_C3) ? 3'd4 : 3'd6;

    // Reply byte selected by position; C1 reads the live cfg registers
    always_comb begin
        reply_byte = '0;
        if (cmd_q == HEAD_C1) begin
            case (idx_q)
                3'd0:    reply_byte = save_q ? HEAD_C0 : HEAD_C2;
                3'd1:    reply_byte = addh_q;
                3'd2:    reply_byte = addl_q;
                3'd3:    reply_byte = sped_q;
                3'd4:    reply_byte = chan_q;
                default: reply_byte = opt_q;
            endcase
        end else if (cmd_q == HEAD_C3) begin
            case (idx_q)
                3'd0:    reply_byte = HEAD_C3;
                3'd1:    reply_byte = VER_ID;
                3'd2:    reply_byte = VERSION_BYTE;
                default: reply_byte = FEATURE_BYTE;
            endcase
        end else if (idx_q < 3'd6) begin
            reply_byte = buf_q[idx_q];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        tx_use_d  = 1'b0;
        rst_req_d = 1'b0;
        addh_d    = addh_q;
        addl_d    = addl_q;
        sped_d    = sped_q;
        chan_d    = chan_q;
        opt_d     = opt_q;
        save_d    = save_q;

        case (state_q)
            S_IDLE: begin
                if (head_ok) begin
                    cmd_d    = bus.rx_data;
                    buf_d[0] = bus.rx_data;
                    cnt_d    = 3'd1;
                    tmo_d    = '0;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (!mode_sleep) begin
                    state_d = S_IDLE;
                end else if (tmo_q == TW'(CMD_TIMEOUT)) begin
                    // Timed out: a byte in this same cycle starts a fresh frame
                    state_d = S_IDLE;
                    if (head_ok) begin
                        cmd_d    = bus.rx_data;
                        buf_d[0] = bus.rx_data;
                        cnt_d    = 3'd1;
                        tmo_d    = '0;
                        state_d  = S_COLLECT;
                    end
                end else if (bus.rx_flag) begin
                    if (!wide_cmd && (bus.rx_data != cmd_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        buf_d[cnt_q] = bus.rx_data;
                        cnt_d        = cnt_q + 3'd1;
                        tmo_d        = '0;
                        if (cnt_q == frame_len - 3'd1) begin
                            state_d = S_EXEC;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_EXEC: begin
                idx_d   = 3'd0;
                gap_d   = 1'b0;
                state_d = S_RESPOND;
                if (wide_cmd) begin
                    addh_d = buf_q[1];
                    addl_d = buf_q[2];
                    sped_d = buf_q[3];
                    chan_d = buf_q[4];
                    opt_d  = buf_q[5];
                    save_d = (cmd_q == HEAD_C0);
                end else if (cmd_q == HEAD_C4) begin
                    rst_req_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RESPOND: begin
                // gap_q enforces one idle cycle between reply strobes
                if (idx_q == reply_len) begin
                    state_d = S_IDLE;
                end else if (gap_q) begin
                    gap_d = 1'b0;
                end else if (bus.tx_ready) begin
                    tx_data_d = reply_byte;
                    tx_use_d  = 1'b1;
                    idx_d     = idx_q + 3'd1;
                    gap_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            for (int i = 0; i < 6; i++) buf_q[i] <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            gap_q     <= 1'b0;
            tx_data_q <= '0;
            tx_use_q  <= 1'b0;
            rst_req_q <= 1'b0;
            busy_q    <= 1'b0;
            addh_q    <= DEF_ADDH;
            addl_q    <= DEF_ADDL;
            sped_q    <= DEF_SPED;
            chan_q    <= DEF_CHAN;
            opt_q     <= DEF_OPTION;
            save_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            tx_use_q  <= tx_use_d;
            rst_req_q <= rst_req_d;
            busy_q    <= (state_d != S_IDLE);
            addh_q    <= addh_d;
            addl_q    <= addl_d;
            sped_q    <= sped_d;
            chan_q    <= chan_d;
            opt_q     <= opt_d;
            save_q    <= save_d;
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_use  = tx_use_q;
    assign cfg_addh    = addh_q;
    assign cfg_addl    = addl_q;
    assign cfg_sped    = sped_q;
    assign cfg_chan    = chan_q;
    assign cfg_option  = opt_q;
    assign cfg_save    = save_q;
    assign reset_req   = rst_req_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_config_command_parser.sv
// Randomized frame-level bench for config_command_parser with a behavioural reference model.
module tb_config_command_parser;
    localparam int unsigned T   = 960;
    localparam int          LIM = 2 * T + 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_sleep = 1'b0;
    logic [7:0] cfg_addh, cfg_addl, cfg_sped, cfg_chan, cfg_option;
    logic       cfg_save, reset_req, busy;

    config_command_parser_if #(.DATA_WIDTH(8)) bus ();

    config_command_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_sleep (mode_sleep),
        .bus        (bus),
        .cfg_addh   (cfg_addh),
        .cfg_addl   (cfg_addl),
        .cfg_sped   (cfg_sped),
        .cfg_chan   (cfg_chan),
        .cfg_option (cfg_option),
        .cfg_save   (cfg_save),
        .reset_req  (reset_req),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] frame[$];
    logic [7:0] m_cfg [5];
    logic       m_save;
    int         m_rr = 0;
    int         rr_pulses = 0;
    int         rr_cycles = 0;
    logic       prev_use = 1'b0;
    logic       prev_rr = 1'b0;
    logic       rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [63:0] dut_cfg();
        return {23'b0, cfg_addh, cfg_addl, cfg_sped, cfg_chan, cfg_option, cfg_save};
    endfunction

    function automatic logic [63:0] mdl_cfg();
        return {23'b0, m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3], m_cfg[4], m_save};
    endfunction

    task automatic model_reset();
        m_cfg[0] = 8'h00; m_cfg[1] = 8'h00; m_cfg[2] = 8'h1A;
        m_cfg[3] = 8'h17; m_cfg[4] = 8'h44; m_save = 1'b0;
    endtask

    // One clock: sample outputs at the falling edge, then update tx_ready
    task automatic step();
        @(negedge clk);
        if (bus.tx_use) begin
            tx_q.push_back(bus.tx_data);
            check("tx_spacing", 64'(prev_use), 64'd0);
        end
        prev_use = bus.tx_use;
        if (reset_req) begin
            rr_cycles++;
            if (!prev_rr) rr_pulses++;
        end
        prev_rr = reset_req;
        if (rdy_rand) bus.tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        step();
        bus.rx_flag = 1'b0;
    endtask

    // Frame-level rules: what a complete byte sequence should do
    task automatic model_frame(input logic ms);
        logic [7:0] h;
        logic       same;
        if (!ms || frame.size() == 0) return;
        h = frame[0];
        same = 1'b1;
        foreach (frame[i]) if (frame[i] != h) same = 1'b0;
        if ((h == 8'hC0 || h == 8'hC2) && frame.size() == 6) begin
            foreach (frame[i]) exp_q.push_back(frame[i]);
            for (int i = 0; i < 5; i++) m_cfg[i] = frame[i+1];
            m_save = (h == 8'hC0);
        end else if (frame.size() == 3 && same && h == 8'hC1) begin
            exp_q.push_back(m_save ? 8'hC0 : 8'hC2);
            for (int i = 0; i < 5; i++) exp_q.push_back(m_cfg[i]);
        end else if (frame.size() == 3 && same && h == 8'hC3) begin
            exp_q.push_back(8'hC3); exp_q.push_back(8'h32);
            exp_q.push_back(8'h0D); exp_q.push_back(8'h14);
        end else if (frame.size() == 3 && same && h == 8'hC4) begin
            m_rr++;
        end
    endtask

    task automatic finish_frame(input logic ms);
        int n;
        model_frame(ms);
        n = 0;
        while (busy && n < LIM) begin
            step();
            n++;
        end
        check("idle_wait", 64'(busy), 64'd0);
        step();
        step();
        check("reply_len", 64'(tx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
            check($sformatf("reply[%0d]", i), 64'(tx_q[i]), 64'(exp_q[i]));
        check("cfg", dut_cfg(), mdl_cfg());
        check("rr_pulses", 64'(rr_pulses), 64'(m_rr));
        check("rr_width", 64'(rr_cycles), 64'(rr_pulses));
        tx_q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame(input logic ms, input int max_gap);
        mode_sleep = ms;
        foreach (frame[i]) begin
            send_byte(frame[i]);
            repeat ($urandom_range(0, max_gap)) step();
        end
        mode_sleep = 1'b1;
        finish_frame(ms);
    endtask

    task automatic set3(input logic [7:0] b);
        frame.delete();
        repeat (3) frame.push_back(b);
    endtask

    task automatic set6(input logic [7:0] a, b, c, d, e, f);
        frame.delete();
        frame.push_back(a); frame.push_back(b); frame.push_back(c);
        frame.push_back(d); frame.push_back(e); frame.push_back(f);
    endtask

    initial begin
        int         n;
        int         kind;
        logic [7:0] h, x;
        logic       ms;
        logic [7:0] heads [3];

        heads[0] = 8'hC1; heads[1] = 8'hC3; heads[2] = 8'hC4;
        bus.rx_data = '0; bus.rx_flag = 1'b0; bus.tx_ready = 1'b1;
        model_reset();

        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_use", 64'(bus.tx_use), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_reset_req", 64'(reset_req), 64'd0);
        check("rst_cfg", dut_cfg(), mdl_cfg());
        rst_n = 1'b1;
        mode_sleep = 1'b1;
        repeat (2) step();

        // Basic write, read-back, volatile write, reset request
        set6(8'hC0, 8'hCD, 8'hAB, 8'h3D, 8'h17, 8'hC4); run_frame(1'b1, 2);
        set3(8'hC1); run_frame(1'b1, 2);
        set6(8'hC2, 8'h00, 8'h01, 8'h1A, 8'h17, 8'h44); run_frame(1'b1, 0);
        set3(8'hC1); run_frame(1'b1, 0);
        set3(8'hC4); run_frame(1'b1, 1);

        // Inter-byte timeout drops a partial frame
        send_byte(8'hC1);
        send_byte(8'hC1);
        repeat (T - 2) step();
        check("tmo_pre_busy", 64'(busy), 64'd1);
        repeat (4) step();
        check("tmo_post_busy", 64'(busy), 64'd0);
        check("tmo_no_tx", 64'(tx_q.size()), 64'd0);
        set3(8'hC1); run_frame(1'b1, 1);

        // Last byte arriving just before the timeout is still accepted
        send_byte(8'hC3);
        send_byte(8'hC3);
        repeat (T - 1) step();
        send_byte(8'hC3);
        set3(8'hC3);
        finish_frame(1'b1);

        // Mismatched 3-byte frame; trailing C1 starts a partial that times out
        frame.delete();
        frame.push_back(8'hC1); frame.push_back(8'hC3); frame.push_back(8'hC1);
        run_frame(1'b1, 0);

        // Bytes with mode_sleep low are ignored
        set6(8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55); run_frame(1'b0, 1);

        // mode_sleep falling mid-frame drops it
        send_byte(8'hC0); send_byte(8'h11); send_byte(8'h22);
        mode_sleep = 1'b0;
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        mode_sleep = 1'b1;
        frame.delete();
        finish_frame(1'b1);

        // Reply stalls while tx_ready is low
        bus.tx_ready = 1'b0;
        set3(8'hC3);
        foreach (frame[i]) send_byte(frame[i]);
        repeat (30) step();
        check("stall_no_tx", 64'(tx_q.size()), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        bus.tx_ready = 1'b1;
        finish_frame(1'b1);

        // Randomized frames
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 7);
            ms = 1'b1;
            frame.delete();
            case (kind)
                0, 1: begin
                    frame.push_back(kind == 0 ? 8'hC0 : 8'hC2);
                    repeat (5) frame.push_back(8'($urandom));
                end
                2: set3(8'hC1);
                3: set3(8'hC3);
                4: set3(8'hC4);
                5: begin
                    h = heads[$urandom_range(0, 2)];
                    x = 8'($urandom);
                    if (x == h) x = ~h;
                    frame.push_back(h);
                    if ($urandom_range(0, 1) == 1) frame.push_back(h);
                    frame.push_back(x);
                end
                6: begin
                    x = 8'($urandom);
                    if (x inside {[8'hC0:8'hC4]}) x = 8'h55;
                    frame.push_back(x);
                end
                default: begin
                    ms = 1'b0;
                    frame.push_back(8'hC0);
                    repeat (5) frame.push_back(8'($urandom));
                end
            endcase
            run_frame(ms, 3);
        end
        rdy_rand = 1'b0;
        bus.tx_ready = 1'b1;

        // Asynchronous reset during the third reply byte
        set3(8'hC1);
        foreach (frame[i]) send_byte(frame[i]);
        n = 0;
        while (tx_q.size() < 3 && n < 200) begin
            step();
            n++;
        end
        check("mid_reply_reached", 64'(tx_q.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        check("arst_tx_use", 64'(bus.tx_use), 64'd0);
        check("arst_tx_data", 64'(bus.tx_data), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_reset_req", 64'(reset_req), 64'd0);
        model_reset();
        check("arst_cfg", dut_cfg(), mdl_cfg());
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        check("post_rst_no_tx", 64'(tx_q.size()), 64'd3);
        tx_q.delete();
        set3(8'hC1); run_frame(1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
